// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send,
// then shifts a command byte out on device clock edges and checks the acknowledge.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES     = 960,
    parameter int FIRST_EDGE_TIMEOUT = 142860,
    parameter int BIT_TIMEOUT        = 19048,
    parameter int FILT_LEN           = 4
) (
    input  logic       clk_kb,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);
    localparam int TO_MAX  = (FIRST_EDGE_TIMEOUT > BIT_TIMEOUT) ? FIRST_EDGE_TIMEOUT : BIT_TIMEOUT;
    localparam int CNT_MAX = (TO_MAX > INHIBIT_CYCLES) ? TO_MAX : INHIBIT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] FIRST_LAST = CW'(FIRST_EDGE_TIMEOUT - 1);
    localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_WAIT_FIRST, S_DATA,
        S_ACK, S_WAIT_IDLE, S_DONE, S_ERR
    } state_t;

    state_t              state_q, state_nxt;
    logic [1:0]          clk_sync, data_sync;
    logic [FILT_LEN-1:0] filt_sh;
    logic                clk_filt;
    logic                data_s, fe;
    logic [9:0]          sh_q;
    logic [3:0]          n_q;
    logic [CW-1:0]       cnt_q;
    logic                accept, shift_en;
    logic                ready_nxt, clk_oe_nxt, data_oe_nxt, busy_nxt, done_nxt, err_nxt;

    // Lines idle high, so the conditioning chain resets to 1 to avoid a false edge.
    always_ff @(posedge clk_kb) begin
        if (!rst_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            filt_sh   <= '1;
            clk_filt  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
            filt_sh   <= {filt_sh[FILT_LEN-2:0], clk_sync[1]};
            if (&filt_sh)
                clk_filt <= 1'b1;
            else if (~|filt_sh)
                clk_filt <= 1'b0;
        end
    end

    assign data_s   = data_sync[1];
    assign fe       = clk_filt & ~|filt_sh;
    assign accept   = tx_valid & tx_ready;
    assign shift_en = fe & ((state_q == S_WAIT_FIRST) | (state_q == S_DATA));

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE:       if (accept) state_nxt = S_INHIBIT;
            S_INHIBIT:    if (cnt_q == INH_LAST) state_nxt = S_REQ;
            S_REQ:        state_nxt = S_WAIT_FIRST;
            S_WAIT_FIRST: begin
                if (fe)                        state_nxt = S_DATA;
                else if (cnt_q == FIRST_LAST)  state_nxt = S_ERR;
            end
            S_DATA: begin
                if (fe) begin
                    if (n_q == 4'd8) state_nxt = S_ACK;
                end else if (cnt_q == BIT_LAST) begin
                    state_nxt = S_ERR;
                end
            end
            S_ACK: begin
                if (fe)                     state_nxt = data_s ? S_ERR : S_WAIT_IDLE;
                else if (cnt_q == BIT_LAST) state_nxt = S_ERR;
            end
            S_WAIT_IDLE: begin
                if (clk_filt && data_s)     state_nxt = S_DONE;
                else if (cnt_q == BIT_LAST) state_nxt = S_ERR;
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_comb begin
        ready_nxt   = 1'b0;
        clk_oe_nxt  = 1'b0;
        data_oe_nxt = 1'b0;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        busy_nxt    = (state_nxt != S_IDLE);
        case (state_nxt)
            S_IDLE:       ready_nxt = 1'b1;
            S_INHIBIT:    clk_oe_nxt = 1'b1;
            S_REQ: begin
                clk_oe_nxt  = 1'b1;
                data_oe_nxt = 1'b1;
            end
            S_WAIT_FIRST: data_oe_nxt = 1'b1;
            S_DATA:       data_oe_nxt = shift_en ? ~sh_q[0] : ps2_data_oe;
            S_DONE:       done_nxt = 1'b1;
            S_ERR:        err_nxt = 1'b1;
            default:      ;
        endcase
    end

    always_ff @(posedge clk_kb) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            tx_ready    <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            tx_ready    <= ready_nxt;
            ps2_clk_oe  <= clk_oe_nxt;
            ps2_data_oe <= data_oe_nxt;
            busy        <= busy_nxt;
            tx_done     <= done_nxt;
            tx_err      <= err_nxt;
        end
    end

    // Frame shifter holds {stop, parity, data}; bit 0 is the next bit to drive.
    always_ff @(posedge clk_kb) begin
        if (!rst_n) begin
            sh_q  <= '0;
            n_q   <= '0;
            cnt_q <= '0;
        end else begin
            if (state_nxt != state_q || state_q == S_IDLE || (fe && state_q == S_DATA))
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + CW'(1);
            if (accept) begin
                sh_q <= {1'b1, ~^tx_data, tx_data};
                n_q  <= '0;
            end else if (shift_en) begin
                sh_q <= {1'b0, sh_q[9:1]};
                if (state_q == S_DATA)
                    n_q <= n_q + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a behavioural PS/2 device clocks frames out
// of the DUT and the sampled bit stream is compared with a start/data/parity/stop model.
module tb_ps2_host_tx;
    logic       clk_kb = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_err;
    logic       dev_clk = 1'b1, dev_data = 1'b1, glitch = 1'b0;
    logic       ps2_clk_in, ps2_data_in;

    int n_assert = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [10:0] dev_bits;
    int n_done, n_err, n_inh, n_req, busy_gap, both, rel_cyc, err_cyc, last_chg;
    bit timed_out;
    logic [1:0] end_oe;

    assign ps2_clk_in  = ~ps2_clk_oe & dev_clk & ~glitch;
    assign ps2_data_in = ~ps2_data_oe & dev_data;

    ps2_host_tx #(
        .INHIBIT_CYCLES(8), .FIRST_EDGE_TIMEOUT(400), .BIT_TIMEOUT(200), .FILT_LEN(4)
    ) dut (
        .clk_kb(clk_kb), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .busy(busy),
        .tx_done(tx_done), .tx_err(tx_err)
    );

    always #5 clk_kb = ~clk_kb;
    always @(posedge clk_kb) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference frame as seen on the wire: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] exp_stream(input logic [7:0] d);
        int ones = 0;
        logic [10:0] s;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        s[0] = 1'b0;
        for (int i = 0; i < 8; i++) s[i+1] = d[i];
        s[9]  = (ones % 2 == 0);
        s[10] = 1'b1;
        return s;
    endfunction

    task automatic send(input logic [7:0] d);
        int t = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && t < 100) begin @(negedge clk_kb); t++; end
        @(negedge clk_kb);
    endtask

    task automatic dev(input int n_edges, input bit ack_low, input int glitch_edge);
        int t = 0;
        dev_bits = '1;
        while (!(!ps2_clk_oe && ps2_data_oe) && t < 2000) begin @(negedge clk_kb); t++; end
        if (t < 2000) begin
            repeat (10) @(negedge clk_kb);
            dev_bits[0] = ps2_data_in;
            for (int e = 1; e <= n_edges; e++) begin
                dev_clk = 1'b0;
                if (e == 11 && ack_low) dev_data = 1'b0;
                repeat (20) @(negedge clk_kb);
                dev_clk = 1'b1;
                if (e <= 10) dev_bits[e] = ps2_data_in;
                if (e == glitch_edge) begin
                    repeat (8) @(negedge clk_kb);
                    glitch = 1'b1;
                    @(negedge clk_kb);
                    glitch = 1'b0;
                    repeat (11) @(negedge clk_kb);
                end else begin
                    repeat (20) @(negedge clk_kb);
                end
                dev_data = 1'b1;
            end
        end
    endtask

    task automatic mon(input bit hold);
        int budget = 3000;
        bit prev_clk = 1'b1;
        bit prev_doe;
        n_done = 0; n_err = 0; n_inh = 0; n_req = 0; busy_gap = 0; both = 0;
        rel_cyc = -1; err_cyc = -1; last_chg = -1; timed_out = 1'b1;
        prev_doe = ps2_data_oe;
        while (budget > 0) begin
            if (ps2_clk_oe && !ps2_data_oe) n_inh++;
            if (ps2_clk_oe && ps2_data_oe) n_req++;
            if (prev_clk && !ps2_clk_oe && rel_cyc < 0) rel_cyc = cyc;
            if (!ps2_clk_oe && ps2_data_oe != prev_doe && !tx_err) last_chg = cyc;
            if (tx_done) n_done++;
            if (tx_err) begin n_err++; err_cyc = cyc; end
            if (tx_done && tx_err) both++;
            if (tx_ready) begin timed_out = 1'b0; break; end
            if (!busy) busy_gap++;
            if (hold) begin
                if (tx_done || tx_err) tx_valid = 1'b0;
                else tx_data = 8'($urandom);
            end
            prev_clk = ps2_clk_oe;
            prev_doe = ps2_data_oe;
            @(negedge clk_kb);
            budget--;
        end
        end_oe = {ps2_clk_oe, ps2_data_oe};
    endtask

    task automatic frame(input logic [7:0] d, input int n_edges, input bit ack_low,
                         input int glitch_edge, input bit hold, input bit use_dev);
        send(d);
        if (!hold) tx_valid = 1'b0;
        fork
            begin if (use_dev) dev(n_edges, ack_low, glitch_edge); end
            mon(hold);
        join
        chk("mon_bound", {31'b0, timed_out}, 0);
        chk("end_oe", {30'b0, end_oe}, 0);
        chk("done_err_overlap", both, 0);
        chk("busy_gap", busy_gap, 0);
    endtask

    task automatic good_frame(input string tag, input logic [7:0] d, input int glitch_edge, input bit hold);
        frame(d, 11, 1'b1, glitch_edge, hold, 1'b1);
        chk({tag, "_bits"}, {21'b0, dev_bits}, {21'b0, exp_stream(d)});
        chk({tag, "_inhibit"}, n_inh, 8);
        chk({tag, "_req"}, n_req, 1);
        chk({tag, "_done"}, n_done, 1);
        chk({tag, "_err"}, n_err, 0);
    endtask

    initial begin
        logic [7:0] rb;
        repeat (3) @(negedge clk_kb);
        chk("reset_outs", {26'b0, tx_ready, ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_err}, 0);
        rst_n = 1'b1;
        @(negedge clk_kb);
        chk("ready_after_reset", {31'b0, tx_ready}, 1);

        good_frame("ed", 8'hED, 0, 1'b0);
        chk("ed_stream_literal", {21'b0, dev_bits}, 32'h7DA);
        good_frame("x01", 8'h01, 0, 1'b0);
        chk("x01_parity", {31'b0, dev_bits[9]}, 0);
        good_frame("x00", 8'h00, 0, 1'b0);
        chk("x00_parity", {31'b0, dev_bits[9]}, 1);
        good_frame("xff", 8'hFF, 0, 1'b0);
        chk("xff_parity", {31'b0, dev_bits[9]}, 1);
        for (int i = 0; i < 4; i++) begin
            rb = 8'($urandom);
            good_frame("rand", rb, 0, 1'b0);
        end

        // No device clock: first-edge timeout.
        frame(8'h55, 0, 1'b1, 0, 1'b0, 1'b0);
        chk("nodev_err", n_err, 1);
        chk("nodev_done", n_done, 0);
        chk("nodev_latency", err_cyc - rel_cyc, 400);

        // Missing acknowledge on the 11th edge.
        frame(8'hAA, 11, 1'b0, 0, 1'b0, 1'b1);
        chk("nack_err", n_err, 1);
        chk("nack_done", n_done, 0);
        chk("nack_bits", {21'b0, dev_bits}, {21'b0, exp_stream(8'hAA)});

        // Device stalls after 4 edges; 0x08 makes the 4th edge flip data_oe.
        frame(8'h08, 4, 1'b1, 0, 1'b0, 1'b1);
        chk("stall_err", n_err, 1);
        chk("stall_done", n_done, 0);
        chk("stall_latency", err_cyc - last_chg, 200);

        // Reset while bit 5 is on the wire.
        send(8'h5A);
        tx_valid = 1'b0;
        dev(6, 1'b1, 0);
        chk("mid_busy", {31'b0, busy}, 1);
        rst_n = 1'b0;
        @(negedge clk_kb);
        chk("rst_oe", {30'b0, ps2_clk_oe, ps2_data_oe}, 0);
        for (int i = 0; i < 3; i++) begin
            chk("rst_pulses", {30'b0, tx_done, tx_err}, 0);
            @(negedge clk_kb);
        end
        rst_n = 1'b1;
        @(negedge clk_kb);
        chk("rst_ready", {31'b0, tx_ready}, 1);
        chk("rst_pulses_after", {30'b0, tx_done, tx_err}, 0);
        good_frame("f4", 8'hF4, 0, 1'b0);

        // tx_valid held with changing data: only the first byte goes out.
        good_frame("hold", 8'h3C, 0, 1'b1);
        repeat (5) @(negedge clk_kb);
        chk("hold_no_second", {30'b0, tx_ready, busy}, 2);

        // Short clock glitch must not advance the bit counter.
        good_frame("glitch", 8'h96, 3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
